// File: rtl/fifo_reader.sv
// Read side of a sync FIFO with registered read data: issues read requests and
// re-times the returned words into a 3-entry skid buffer feeding a valid/ready sink.
module fifo_reader #(
    parameter type         DTYPE = int,
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    output logic             fifo_rreq,
    input  DTYPE             fifo_dout,
    input  logic             fifo_empty,
    output logic             m_valid,
    input  logic             m_ready,
    output DTYPE             m_data,
    output logic [1:0]       level,
    output logic [CNT_W-1:0] xfer_count
);

    logic       inflight;
    logic       rd_fire;
    logic       xfer;
    logic       capture;
    logic [1:0] wr_idx;
    logic [1:0] level_nxt;
    DTYPE       slots     [3];
    DTYPE       slots_nxt [3];

    // Requests are limited so every word already fired is guaranteed a slot.
    assign fifo_rreq = !rst && !flush && !fifo_empty
                       && (({1'b0, level} + {2'b0, inflight}) < 3'd3);
    assign rd_fire   = fifo_rreq && !fifo_empty;
    assign m_valid   = (level != 2'd0);
    assign m_data    = slots[0];
    assign xfer      = m_valid && m_ready;
    assign capture   = inflight && !flush;
    assign wr_idx    = level - {1'b0, xfer};

    always_comb begin
        slots_nxt = slots;
        level_nxt = level;
        if (xfer) begin
            slots_nxt[0] = slots[1];
            slots_nxt[1] = slots[2];
            level_nxt    = level - 2'd1;
        end
        // Write lands behind the surviving entries, after any shift.
        if (capture) begin
            slots_nxt[wr_idx] = fifo_dout;
            level_nxt         = level_nxt + 2'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            inflight   <= 1'b0;
            level      <= 2'd0;
            xfer_count <= '0;
            for (int unsigned i = 0; i < 3; i++) begin
                slots[i] <= '0;
            end
        end else begin
            xfer_count <= xfer_count + CNT_W'(xfer);
            if (flush) begin
                inflight <= 1'b0;
                level    <= 2'd0;
            end else begin
                inflight <= rd_fire;
                level    <= level_nxt;
                slots    <= slots_nxt;
            end
        end
    end

endmodule

// File: tb/tb_fifo_reader.sv
// Randomized and directed checks of fifo_reader against a queue-based model of
// fired words and their arrival times, driven from a behavioural sync FIFO.
module tb_fifo_reader;

    localparam int CW = 16;

    logic          clk = 1'b0;
    logic          rst;
    logic          flush;
    logic          fifo_rreq;
    int            fifo_dout;
    logic          fifo_empty;
    logic          m_valid;
    logic          m_ready;
    int            m_data;
    logic [1:0]    level;
    logic [CW-1:0] xfer_count;

    fifo_reader #(.DTYPE(int), .CNT_W(CW)) dut (
        .clk        (clk),
        .rst        (rst),
        .flush      (flush),
        .fifo_rreq  (fifo_rreq),
        .fifo_dout  (fifo_dout),
        .fifo_empty (fifo_empty),
        .m_valid    (m_valid),
        .m_ready    (m_ready),
        .m_data     (m_data),
        .level      (level),
        .xfer_count (xfer_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          data;
        int unsigned cyc;
    } word_t;

    int            src_q[$];
    word_t         mdl_q[$];
    int unsigned   cyc = 0;
    logic [CW-1:0] mdl_cnt = '0;
    int            total = 0;
    int            bad = 0;
    int            deliv_data[$];
    int unsigned   deliv_cyc[$];
    int unsigned   fire_cyc[$];
    logic          prev_stall = 1'b0;
    int            prev_data = 0;

    task automatic chk(input string name, input longint act, input longint exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Behavioural sync FIFO: registered read data, one word per accepted request.
    always @(posedge clk) begin
        if (fifo_rreq && !fifo_empty) begin
            fifo_dout  <= src_q.pop_front();
            fifo_empty <= (src_q.size() == 0);
        end
    end

    // Model: a fired word becomes visible two cycles later and leaves on xfer.
    always @(negedge clk) begin
        int   vis;
        logic e_valid;
        logic e_rreq;
        cyc++;
        if (rst) begin
            chk("rst_m_valid", m_valid, 0);
            chk("rst_level", level, 0);
            chk("rst_fifo_rreq", fifo_rreq, 0);
            chk("rst_xfer_count", xfer_count, 0);
            chk("rst_m_data", m_data, 0);
            mdl_q.delete();
            mdl_cnt    = '0;
            prev_stall = 1'b0;
        end else begin
            vis = 0;
            foreach (mdl_q[i]) if (mdl_q[i].cyc + 2 <= cyc) vis++;
            e_valid = (vis != 0);
            e_rreq  = !flush && (src_q.size() != 0) && (mdl_q.size() < 3);
            chk("m_valid", m_valid, e_valid);
            chk("level", level, vis);
            chk("fifo_rreq", fifo_rreq, e_rreq);
            chk("xfer_count", xfer_count, mdl_cnt);
            if (e_valid) chk("m_data", m_data, mdl_q[0].data);
            if (prev_stall) chk("stall_hold", m_data, prev_data);
            prev_stall = m_valid && !m_ready && !flush;
            prev_data  = m_data;
            if (e_valid && m_ready) begin
                mdl_cnt++;
                deliv_data.push_back(mdl_q[0].data);
                deliv_cyc.push_back(cyc);
            end
            if (flush) begin
                mdl_q.delete();
            end else begin
                if (e_valid && m_ready) void'(mdl_q.pop_front());
                if (e_rreq) begin
                    mdl_q.push_back('{src_q[0], cyc});
                    fire_cyc.push_back(cyc);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input int d);
        src_q.push_back(d);
        fifo_empty = 1'b0;
    endtask

    task automatic clear_logs();
        deliv_data.delete();
        deliv_cyc.delete();
        fire_cyc.delete();
    endtask

    task automatic wait_idle(input string nm);
        int n = 0;
        while ((src_q.size() != 0 || mdl_q.size() != 0) && n < 400) begin
            tick();
            n++;
        end
        chk({nm, "_timeout"}, (n < 400), 1);
    endtask

    initial begin
        int          sent[$];
        int          saved[$];
        int          pushed;
        int          need;
        int          bound;
        logic [CW-1:0] cnt0;

        rst        = 1'b1;
        flush      = 1'b0;
        m_ready    = 1'b0;
        fifo_empty = 1'b1;
        fifo_dout  = 0;
        repeat (3) tick();
        rst = 1'b0;
        tick();

        // Three words, sink always ready.
        clear_logs();
        m_ready = 1'b1;
        push(32'h11); push(32'h22); push(32'h33);
        wait_idle("t1");
        chk("t1_count", deliv_data.size(), 3);
        if (deliv_data.size() == 3 && fire_cyc.size() >= 1) begin
            chk("t1_d0", deliv_data[0], 32'h11);
            chk("t1_d1", deliv_data[1], 32'h22);
            chk("t1_d2", deliv_data[2], 32'h33);
            chk("t1_latency", deliv_cyc[0], fire_cyc[0] + 2);
            chk("t1_back2back", deliv_cyc[2], deliv_cyc[0] + 2);
        end
        chk("t1_xfer_count", xfer_count, 3);

        // Eight words with the sink stalled: buffer fills to three.
        clear_logs();
        m_ready = 1'b0;
        for (int i = 0; i < 8; i++) push(32'hA0 + i);
        repeat (10) tick();
        chk("t2_fires", fire_cyc.size(), 3);
        chk("t2_level", level, 3);
        chk("t2_rreq", fifo_rreq, 0);
        m_ready = 1'b1;
        wait_idle("t2");
        chk("t2_count", deliv_data.size(), 8);
        if (deliv_data.size() == 8)
            for (int i = 0; i < 8; i++) chk("t2_data", deliv_data[i], 32'hA0 + i);

        // 100 random words with random sink backpressure and FIFO gaps.
        clear_logs();
        cnt0   = mdl_cnt;
        pushed = 0;
        bound  = 0;
        while ((pushed < 100 || src_q.size() != 0 || mdl_q.size() != 0) && bound < 2000) begin
            m_ready = 1'($urandom_range(0, 1));
            if (pushed < 100 && $urandom_range(0, 2) != 0) begin
                sent.push_back(int'($urandom));
                push(sent[pushed]);
                pushed++;
            end
            tick();
            bound++;
        end
        m_ready = 1'b1;
        wait_idle("t3");
        chk("t3_count", deliv_data.size(), 100);
        if (deliv_data.size() == 100)
            for (int i = 0; i < 100; i++) chk("t3_data", deliv_data[i], sent[i]);
        chk("t3_xfer_count", xfer_count, CW'(cnt0 + 16'd100));

        // Flush with two words buffered and one in flight.
        clear_logs();
        m_ready = 1'b0;
        for (int i = 0; i < 5; i++) push(32'h50 + i);
        repeat (3) tick();
        chk("t4_pre_level", level, 2);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        chk("t4_post_level", level, 0);
        chk("t4_post_valid", m_valid, 0);
        m_ready = 1'b1;
        wait_idle("t4");
        chk("t4_count", deliv_data.size(), 2);
        if (deliv_data.size() == 2) begin
            chk("t4_d0", deliv_data[0], 32'h53);
            chk("t4_d1", deliv_data[1], 32'h54);
        end

        // Stream up to the counter wrap point, then three more.
        m_ready = 1'b1;
        need    = int'(16'hFFFE) - int'(mdl_cnt);
        pushed  = 0;
        bound   = 0;
        while (pushed < need && bound < need * 2 + 100) begin
            if (src_q.size() < 4) begin
                push(pushed);
                pushed++;
            end
            tick();
            bound++;
        end
        wait_idle("t5a");
        clear_logs();
        chk("t5_pre_wrap", xfer_count, 16'hFFFE);
        push(1); push(2); push(3);
        wait_idle("t5b");
        chk("t5_wrapped", xfer_count, 16'h0001);

        // Asynchronous reset mid-burst.
        m_ready = 1'b1;
        for (int i = 0; i < 6; i++) push(32'h70 + i);
        repeat (3) tick();
        #2;
        rst = 1'b1;
        saved = src_q;
        clear_logs();
        #1;
        chk("t6_valid", m_valid, 0);
        chk("t6_level", level, 0);
        chk("t6_rreq", fifo_rreq, 0);
        chk("t6_count", xfer_count, 0);
        chk("t6_data", m_data, 0);
        @(posedge clk);
        #2;
        rst = 1'b0;
        wait_idle("t6");
        chk("t6_ndeliv", deliv_data.size(), saved.size());
        if (deliv_data.size() == saved.size() && saved.size() != 0) begin
            for (int i = 0; i < saved.size(); i++) chk("t6_order", deliv_data[i], saved[i]);
            chk("t6_latency", deliv_cyc[0], fire_cyc[0] + 2);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
